// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// alu_seq_ctrl : nibble-serial ADD/SUB and shift-and-add MUL over one cla_4bit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module cla_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = x & y;
    assign w_p = x ^ y;

    // Carries expanded from generate/propagate terms, not rippled.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

    assign sum   = w_p ^ w_c[3:0];
    assign c_out = w_c[4];
endmodule

module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);
    localparam int NIB  = WIDTH / 4;
    localparam int HALF = WIDTH / 2;
    localparam int K_W  = (NIB  > 1) ? $clog2(NIB)  : 1;
    localparam int P_W  = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [1:0]     c_op_add    = 2'b00;
    localparam logic [1:0]     c_op_sub    = 2'b01;
    localparam logic [1:0]     c_op_mul    = 2'b10;
    localparam logic [K_W-1:0] c_k_last    = K_W'(NIB - 1);
    localparam logic [P_W-1:0] c_pass_last = P_W'(HALF - 1);

    generate
        if ((WIDTH % 8) != 0) begin : g_width_check
            $error("alu_seq_ctrl: WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDSUB = 2'd1,
        S_MUL    = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [K_W-1:0]   r_k, w_k_nxt;
    logic [P_W-1:0]   r_pass, w_pass_nxt;
    logic             r_creg, w_creg_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_m, w_m_nxt;
    logic [HALF-1:0]  r_q, w_q_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_err, w_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [3:0]       w_add_x;
    logic [3:0]       w_add_y;
    logic [3:0]       w_sum;
    logic             w_cout;
    logic             w_is_sub;

    assign w_is_sub = (r_op == c_op_sub);

    // Adder operand steering lives apart from the FSM so the sum feedback
    // into next-state logic is not a block-level combinational loop.
    always_comb begin
        w_add_x = '0;
        w_add_y = '0;
        if (r_state == S_MUL) begin
            w_add_x = r_acc[{r_k, 2'b00} +: 4];
            w_add_y = r_q[0] ? r_m[{r_k, 2'b00} +: 4] : 4'h0;
        end else begin
            w_add_x = r_a[{r_k, 2'b00} +: 4];
            w_add_y = r_b[{r_k, 2'b00} +: 4] ^ {4{w_is_sub}};
        end
    end

    cla_4bit u_cla (
        .x     (w_add_x),
        .y     (w_add_y),
        .c_in  (r_creg),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_k_nxt      = r_k;
        w_pass_nxt   = r_pass;
        w_creg_nxt   = r_creg;
        w_acc_nxt    = r_acc;
        w_m_nxt      = r_m;
        w_q_nxt      = r_q;
        w_result_nxt = r_result;
        w_carry_nxt  = r_carry;
        w_err_nxt    = r_err;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nxt     = op;
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_result_nxt = '0;
                    w_carry_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_k_nxt      = '0;
                    w_pass_nxt   = '0;
                    w_acc_nxt    = '0;
                    w_m_nxt      = {{(WIDTH - HALF){1'b0}}, a[HALF-1:0]};
                    w_q_nxt      = b[HALF-1:0];
                    w_creg_nxt   = (op == c_op_sub);
                    case (op)
                        c_op_add, c_op_sub: begin
                            w_state_nxt = S_ADDSUB;
                            w_busy_nxt  = 1'b1;
                        end
                        c_op_mul: begin
                            w_state_nxt = S_MUL;
                            w_busy_nxt  = 1'b1;
                        end
                        default: begin
                            w_err_nxt  = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_ADDSUB: begin
                w_acc_nxt[{r_k, 2'b00} +: 4] = w_sum;
                w_creg_nxt                   = w_cout;
                w_k_nxt                      = r_k + 1'b1;
                if (r_k == c_k_last) begin
                    w_k_nxt      = '0;
                    w_result_nxt = w_acc_nxt;
                    w_carry_nxt  = w_is_sub ? ~w_cout : w_cout;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end

            S_MUL: begin
                w_acc_nxt[{r_k, 2'b00} +: 4] = w_sum;
                w_creg_nxt                   = w_cout;
                w_k_nxt                      = r_k + 1'b1;
                // Every pass runs all nibbles even when q[0] is 0: fixed latency.
                if (r_k == c_k_last) begin
                    w_k_nxt    = '0;
                    w_creg_nxt = 1'b0;
                    w_m_nxt    = r_m << 1;
                    w_q_nxt    = r_q >> 1;
                    w_pass_nxt = r_pass + 1'b1;
                    if (r_pass == c_pass_last) begin
                        w_pass_nxt   = '0;
                        w_result_nxt = w_acc_nxt;
                        w_carry_nxt  = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_pass   <= '0;
            r_creg   <= 1'b0;
            r_acc    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_k      <= w_k_nxt;
            r_pass   <= w_pass_nxt;
            r_creg   <= w_creg_nxt;
            r_acc    <= w_acc_nxt;
            r_m      <= w_m_nxt;
            r_q      <= w_q_nxt;
            r_result <= w_result_nxt;
            r_carry  <= w_carry_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign err    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// tb_alu_seq_ctrl : scoreboard bench, arithmetic reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int HALF  = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             err;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             e;
        int               due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic void model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y, output logic [WIDTH-1:0] r,
                                  output logic c, output logic e, output int lat);
        logic [31:0]     s;
        logic [HALF-1:0] xl;
        logic [HALF-1:0] yl;
        xl = x[HALF-1:0];
        yl = y[HALF-1:0];
        s  = '0;
        case (o)
            2'b00: begin
                s = 32'(x) + 32'(y);
                r = s[WIDTH-1:0]; c = s[WIDTH]; e = 1'b0; lat = NIB;
            end
            2'b01: begin
                r = x - y; c = (x < y); e = 1'b0; lat = NIB;
            end
            2'b10: begin
                s = 32'(xl) * 32'(yl);
                r = s[WIDTH-1:0]; c = 1'b0; e = 1'b0; lat = HALF * NIB;
            end
            default: begin
                r = '0; c = 1'b0; e = 1'b1; lat = 0;
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        int   lat;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 200) chk("idle_wait_timeout", 32'(busy), 32'd0);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        model(o, x, y, e.res, e.c, e.e, lat);
        e.due = cyc + lat;
        sb.push_back(e);
        if (o == 2'b11) begin
            chk("inv_busy_low", 32'(busy), 32'd0);
        end else begin
            chk("accept_busy", 32'(busy), 32'd1);
            chk("accept_err_clear", 32'(err), 32'd0);
            chk("accept_result_clear", 32'(result), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("result", 32'(result), 32'(m_e.res));
                chk("carry", 32'(carry), 32'(m_e.c));
                chk("err", 32'(err), 32'(m_e.e));
                chk("latency", 32'(cyc), 32'(m_e.due));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int               n;
        logic [1:0]       ro;
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 16'h1234, 16'h0FCD);
        issue(2'b00, 16'hFFFF, 16'h0001);
        issue(2'b01, 16'h0005, 16'h0007);
        issue(2'b01, 16'h1000, 16'h0001);
        issue(2'b10, 16'hABFF, 16'hCDFF);
        issue(2'b10, 16'h0000, 16'h00FF);

        // A start during MUL must be ignored; the next ADD lands on done.
        issue(2'b10, 16'h0013, 16'h0025);
        repeat (3) @(negedge clk);
        op = 2'b00; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(2'b00, 16'h0001, 16'h0001);

        issue(2'b11, 16'h5555, 16'hAAAA);
        issue(2'b00, 16'h0002, 16'h0003);

        // Reset ten cycles into a MUL discards it without a done pulse.
        issue(2'b10, 16'h00FF, 16'h00FF);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        chk("midreset_carry", 32'(carry), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'b00, 16'h00F0, 16'h0010);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 7 == 3) ry = rx;
            if (i % 9 == 5) rx = 16'hFFFF;
            issue(ro, rx, ry);
        end

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle ALU sequencer for the UART calculator. It time-shares one `cla_4bit` nibble adder to run three operations:
- WIDTH-bit ADD and SUB, nibble-serially.
- Unsigned (WIDTH/2)×(WIDTH/2) MUL, by shift-and-add passes over the same adder.

It sits between the command parser and the result formatter, with a start/busy/done handshake on both sides.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 8. NIB = WIDTH/4 nibble steps per adder pass.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 invalid.
- a  in  WIDTH  operand A; captured on accept.
- b  in  WIDTH  operand B; captured on accept.
- busy  out  1  high while an operation executes.
- done  out  1  one-cycle pulse; result, carry and err are valid from this cycle.
- result  out  WIDTH  registered result; held until the next accept.
- carry  out  1  ADD: carry out. SUB: borrow (1 when a < b unsigned). MUL: 0.
- err  out  1  high with done for an invalid op; held until the next accept.

## Operation
- States: IDLE, ADDSUB, MUL. The single internal `cla_4bit` takes one nibble pair per cycle; its c_out feeds a carry register.
- Accept: `start`=1 in IDLE at edge E0. On E0 the block:
  - latches op, a and b;
  - clears result, carry and err;
  - loads nibble index k=0.
- ADD:
  - carry register starts at 0;
  - each ADDSUB edge: result[4k+3:4k] = a_nib[k] + b_nib[k] + creg, creg ← c_out, k++;
  - after nibble NIB-1: carry = final c_out, go to IDLE.
- SUB:
  - same sequence with B nibbles inverted and carry register starting at 1;
  - carry output = NOT final c_out (borrow).
- MUL:
  - setup: acc=0, m = zero-extended a[WIDTH/2-1:0], q = b[WIDTH/2-1:0]; upper halves of a and b are ignored;
  - WIDTH/2 passes are run, each a full NIB-cycle nibble-serial add with carry-in 0: acc ← acc + (q[0] ? m : 0);
  - on the last nibble edge of each pass: m ← m<<1, q ← q>>1;
  - every pass takes NIB cycles regardless of q[0] (fixed latency);
  - after the final pass: result = acc (the product is exact), carry=0.
- Invalid op (11): at E0 stay in IDLE, assert done=1 and err=1, result=0.
- `start` while busy is ignored; the operands are not re-sampled.
- Back-to-back: `start` in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- Reset, including mid-operation: on the next edge the block forces:
  - state IDLE;
  - busy, done, carry and err = 0;
  - result = 0;
  - k, acc, m and q cleared.
  The in-flight operation is discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, result=0, carry=0, err=0.
- busy rises at E0 and falls at the edge that raises done.
- ADD/SUB: done is high in the cycle after edge E0+NIB (NIB cycles of busy; 4 for WIDTH=16).
- MUL: done follows edge E0+(WIDTH/2)·NIB (32 cycles for WIDTH=16).
- Invalid op: done follows E0 directly; busy never rises.
- done is exactly one cycle wide. result, carry and err change only at an accept, at completion, or at reset.

## Test plan
- ADD a=0x1234, b=0x0FCD → result 0x2201, carry 0; done exactly 4 cycles after accept; busy high for 4 cycles.
- ADD 0xFFFF+0x0001 → result 0x0000, carry 1. SUB 0x0005−0x0007 → 0xFFFE, carry 1. SUB 0x1000−0x0001 → 0x0FFF, carry 0.
- MUL a=0xABFF, b=0xCDFF → result 0xFE01, carry 0; done 32 cycles after accept. MUL 0x0000×0x00FF → 0x0000 with the same latency.
- Re-pulse start with op=ADD during MUL busy → ignored, MUL result unchanged. A start coincident with done is accepted: back-to-back ADD 0x0001+0x0001 → 0x0002.
- op=11 → done and err high one cycle after accept, result 0x0000, busy stays 0. The next valid op clears err.
- Assert rst for one cycle at cycle 10 of a MUL → all outputs 0, no done pulse. A following ADD 0x00F0+0x0010 → 0x0100 with normal 4-cycle latency.
